// File: rtl/seq_ctrl_unit_if.sv
// Bus bundle between the sequencer and its instruction ROM / accumulator datapath.
// master = sequencer side, slave = ROM/datapath side.
interface seq_ctrl_unit_if;
   logic        run;
   logic [15:0] instr;
   logic        acc_neg;
   logic [7:0]  pc_addr;
   logic [15:0] ir;
   logic        acc_clr;
   logic        acc_com;
   logic        acc_shr;
   logic        acc_csl;
   logic        acc_ld;
   logic        acc_add;
   logic        mem_re;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic        halted;
   logic        illegal;
   logic [15:0] instr_cnt;

   modport master (
      input  run, instr, acc_neg,
      output pc_addr, ir, acc_clr, acc_com, acc_shr, acc_csl, acc_ld, acc_add,
             mem_re, mem_we, mem_addr, halted, illegal, instr_cnt
   );

   modport slave (
      output run, instr, acc_neg,
      input  pc_addr, ir, acc_clr, acc_com, acc_shr, acc_csl, acc_ld, acc_add,
             mem_re, mem_we, mem_addr, halted, illegal, instr_cnt
   );
endinterface

// File: rtl/seq_ctrl_unit.sv
// Instruction sequencer: fetch/execute/memory FSM driving single-cycle accumulator
// and data-memory strobes, with halt, sticky illegal-opcode flag and retire counter.
module seq_ctrl_unit #(
   parameter logic [7:0] PC_RESET = 8'h00,
   parameter logic [5:0] HLT_OPC  = 6'b111111
) (
   input logic           clk,
   input logic           rst_n,
   seq_ctrl_unit_if.master bus
);

   localparam logic [5:0] OP_NOP = 6'b000000;
   localparam logic [5:0] OP_CLA = 6'b000001;
   localparam logic [5:0] OP_COM = 6'b000010;
   localparam logic [5:0] OP_SHR = 6'b000011;
   localparam logic [5:0] OP_CSL = 6'b000100;
   localparam logic [5:0] OP_ADD = 6'b000110;
   localparam logic [5:0] OP_STA = 6'b000111;
   localparam logic [5:0] OP_LDA = 6'b001000;
   localparam logic [5:0] OP_JMP = 6'b001001;
   localparam logic [5:0] OP_BAN = 6'b001010;

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

   state_t      state, state_nx;
   logic [7:0]  pc, pc_nx;
   logic [15:0] ir;
   logic [15:0] cnt;
   logic        illegal_q;
   logic [5:0]  opc;
   logic        load_ir, retire, set_illegal;
   logic        clr, com, shr, csl, ld, add, re, we;

   assign opc = ir[15:10];

   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      load_ir     = 1'b0;
      retire      = 1'b0;
      set_illegal = 1'b0;
      clr = 1'b0; com = 1'b0; shr = 1'b0; csl = 1'b0;
      ld  = 1'b0; add = 1'b0; re  = 1'b0; we  = 1'b0;
      case (state)
         IDLE: if (bus.run) state_nx = FETCH;
         FETCH: begin
            if (bus.run) begin
               load_ir  = 1'b1;
               state_nx = EXEC;
            end else begin
               state_nx = IDLE;
            end
         end
         EXEC: begin
            retire   = 1'b1;
            pc_nx    = pc + 8'd1;
            state_nx = FETCH;
            // Halt opcode is checked first so an overridden HLT_OPC wins over any decode below.
            if (opc == HLT_OPC) begin
               pc_nx    = pc;
               state_nx = HALT;
            end else begin
               case (opc)
                  OP_NOP: ;
                  OP_CLA: clr = 1'b1;
                  OP_COM: com = 1'b1;
                  OP_SHR: shr = 1'b1;
                  OP_CSL: csl = 1'b1;
                  OP_STA: we  = 1'b1;
                  OP_LDA, OP_ADD: begin
                     re       = 1'b1;
                     retire   = 1'b0;
                     pc_nx    = pc;
                     state_nx = MEM;
                  end
                  OP_JMP: pc_nx = ir[7:0];
                  OP_BAN: if (bus.acc_neg) pc_nx = ir[7:0];
                  default: set_illegal = 1'b1;
               endcase
            end
         end
         MEM: begin
            retire   = 1'b1;
            pc_nx    = pc + 8'd1;
            state_nx = FETCH;
            if (opc == OP_LDA) ld = 1'b1;
            else               add = 1'b1;
         end
         HALT: state_nx = HALT;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= PC_RESET;
         ir        <= '0;
         cnt       <= '0;
         illegal_q <= 1'b0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (load_ir)     ir        <= bus.instr;
         if (retire)      cnt       <= cnt + 16'd1;
         if (set_illegal) illegal_q <= 1'b1;
      end
   end

   // Strobes are gated by rst_n so a reset landing in EXEC/MEM cancels the pending pulse.
   assign bus.acc_clr   = clr & rst_n;
   assign bus.acc_com   = com & rst_n;
   assign bus.acc_shr   = shr & rst_n;
   assign bus.acc_csl   = csl & rst_n;
   assign bus.acc_ld    = ld  & rst_n;
   assign bus.acc_add   = add & rst_n;
   assign bus.mem_re    = re  & rst_n;
   assign bus.mem_we    = we  & rst_n;
   assign bus.pc_addr   = pc;
   assign bus.ir        = ir;
   assign bus.mem_addr  = ir[9:0];
   assign bus.halted    = (state == HALT);
   assign bus.illegal   = illegal_q;
   assign bus.instr_cnt = cnt;

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// Directed bench for seq_ctrl_unit: ROM model in the bench, checks sampled on the falling edge.
module tb_seq_ctrl_unit;

   localparam logic [7:0] S_CLR = 8'h80;
   localparam logic [7:0] S_COM = 8'h40;
   localparam logic [7:0] S_SHR = 8'h20;
   localparam logic [7:0] S_CSL = 8'h10;
   localparam logic [7:0] S_LD  = 8'h08;
   localparam logic [7:0] S_ADD = 8'h04;
   localparam logic [7:0] S_RE  = 8'h02;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] rom [256];
   logic [7:0]  strb;
   int unsigned errors = 0;
   int unsigned checks = 0;

   seq_ctrl_unit_if bus ();

   seq_ctrl_unit #(.PC_RESET(8'h00), .HLT_OPC(6'b111111)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.instr = rom[bus.pc_addr];
   assign strb = {bus.acc_clr, bus.acc_com, bus.acc_shr, bus.acc_csl,
                  bus.acc_ld, bus.acc_add, bus.mem_re, bus.mem_we};

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.run     = 1'b0;
      bus.acc_neg = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] prg [4];
      logic [7:0]  exp_s [4];

      // Reset state and LDA timing
      do_reset();
      chk("rst_pc", {8'h00, bus.pc_addr}, 16'h0000);
      chk("rst_ir", bus.ir, 16'h0000);
      chk("rst_cnt", bus.instr_cnt, 16'h0000);
      chk("rst_flags", {14'h0, bus.halted, bus.illegal}, 16'h0000);
      chk("rst_strb", {8'h00, strb}, 16'h0000);
      rom[0] = 16'h2001;
      bus.run = 1'b1;
      tick();                                      // FETCH
      chk("lda_c1_strb", {8'h00, strb}, 16'h0000);
      tick();                                      // EXEC
      chk("lda_c2_re", {8'h00, strb}, {8'h00, S_RE});
      chk("lda_maddr", {6'h00, bus.mem_addr}, 16'h0001);
      tick();                                      // MEM
      chk("lda_c3_ld", {8'h00, strb}, {8'h00, S_LD});
      chk("lda_c3_pc", {8'h00, bus.pc_addr}, 16'h0000);
      tick();                                      // FETCH
      chk("lda_pc", {8'h00, bus.pc_addr}, 16'h0001);
      chk("lda_cnt", bus.instr_cnt, 16'h0001);
      rom[1] = 16'h0400;
      bus.run = 1'b0;
      tick();                                      // IDLE, ir not latched
      chk("stop_ir", bus.ir, 16'h2001);
      tick();
      chk("stop_pc", {8'h00, bus.pc_addr}, 16'h0001);
      chk("stop_strb", {8'h00, strb}, 16'h0000);

      // CLA, COM, SHR, CSL on alternating cycles
      do_reset();
      prg[0] = 16'h0400; prg[1] = 16'h0800; prg[2] = 16'h0C00; prg[3] = 16'h1000;
      exp_s[0] = S_CLR;  exp_s[1] = S_COM;  exp_s[2] = S_SHR;  exp_s[3] = S_CSL;
      for (int i = 0; i < 4; i++) rom[i] = prg[i];
      bus.run = 1'b1;
      tick();                                      // FETCH
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("acc_exec", {8'h00, strb}, {8'h00, exp_s[i]});
         tick();
         chk("acc_fetch", {8'h00, strb}, 16'h0000);
      end
      chk("acc_pc", {8'h00, bus.pc_addr}, 16'h0004);
      chk("acc_cnt", bus.instr_cnt, 16'h0004);

      // JMP and BAN
      do_reset();
      rom[0]  = 16'h240E;
      rom[14] = 16'h2802;
      rom[15] = 16'h2802;
      bus.run = 1'b1;
      tick(); tick(); tick();
      chk("jmp_pc", {8'h00, bus.pc_addr}, 16'h000E);
      tick(); tick();
      chk("ban_nt_pc", {8'h00, bus.pc_addr}, 16'h000F);
      bus.acc_neg = 1'b1;
      tick(); tick();
      chk("ban_t_pc", {8'h00, bus.pc_addr}, 16'h0002);
      chk("ban_cnt", bus.instr_cnt, 16'h0003);

      // HLT at 5 holds, only reset leaves
      do_reset();
      rom[5] = 16'hFC00;
      bus.run = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick(); tick();
      end
      chk("pre_hlt_pc", {8'h00, bus.pc_addr}, 16'h0005);
      tick();                                      // EXEC of HLT
      chk("hlt_exec_strb", {8'h00, strb}, 16'h0000);
      tick();
      chk("hlt_halted", {15'h0, bus.halted}, 16'h0001);
      chk("hlt_cnt", bus.instr_cnt, 16'h0006);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hlt_hold", {7'h00, bus.halted, bus.pc_addr}, 16'h0105);
         chk("hlt_strb", {8'h00, strb}, 16'h0000);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("hlt_rst_pc", {8'h00, bus.pc_addr}, 16'h0000);
      chk("hlt_rst_halted", {15'h0, bus.halted}, 16'h0000);

      // Illegal opcode, JMP at FF, NOP wrap at FF
      do_reset();
      rom[0]   = 16'h5400;
      rom[1]   = 16'h24FF;
      rom[255] = 16'h2410;
      rom[16]  = 16'h24FF;
      bus.run = 1'b1;
      tick(); tick();
      chk("ill_exec_strb", {8'h00, strb}, 16'h0000);
      tick();
      chk("ill_flag", {15'h0, bus.illegal}, 16'h0001);
      chk("ill_pc", {8'h00, bus.pc_addr}, 16'h0001);
      chk("ill_cnt", bus.instr_cnt, 16'h0001);
      tick(); tick();
      chk("to_ff_pc", {8'h00, bus.pc_addr}, 16'h00FF);
      tick(); tick();
      chk("jmp_ff_pc", {8'h00, bus.pc_addr}, 16'h0010);
      rom[255] = 16'h0000;
      tick(); tick();
      chk("back_ff_pc", {8'h00, bus.pc_addr}, 16'h00FF);
      tick(); tick();
      chk("wrap_pc", {8'h00, bus.pc_addr}, 16'h0000);
      chk("ill_sticky", {15'h0, bus.illegal}, 16'h0001);
      do_reset();
      chk("ill_rst", {15'h0, bus.illegal}, 16'h0000);

      // Reset during MEM of ADD cancels acc_add
      rom[0] = 16'h1803;
      bus.run = 1'b1;
      tick(); tick();
      chk("add_re", {8'h00, strb}, {8'h00, S_RE});
      tick();                                      // MEM
      chk("add_mem_strb", {8'h00, strb}, {8'h00, S_ADD});
      rst_n = 1'b0;
      #1;
      chk("add_cancel", {8'h00, strb}, 16'h0000);
      tick();
      rst_n = 1'b1;
      chk("add_rst_pc", {8'h00, bus.pc_addr}, 16'h0000);
      chk("add_rst_cnt", bus.instr_cnt, 16'h0000);
      chk("add_idle_strb", {8'h00, strb}, 16'h0000);
      tick();                                      // FETCH (proves IDLE before)
      chk("add_fetch_ir", bus.ir, 16'h0000);
      chk("add_fetch_strb", {8'h00, strb}, 16'h0000);
      tick();                                      // EXEC
      chk("add_reexec", {8'h00, strb}, {8'h00, S_RE});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_ctrl_unit.md
SEQ_CTRL_UNIT -- requirements
Module: seq_ctrl_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 8'h00, meaning the program counter value loaded at reset.
REQ-002 SHALL have parameter HLT_OPC, default 6'b111111, meaning the opcode that halts sequencing.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port run, input, 1, enables fetching; level-sensitive.
REQ-006 SHALL have port instr, input, 16, the instruction-ROM word for pc_addr, combinational and valid in the same cycle.
REQ-007 SHALL have port acc_neg, input, 1, accumulator sign bit from the datapath.
REQ-008 SHALL have port pc_addr, output, 8, the instruction-ROM address (the program counter).
REQ-009 SHALL have port ir, output, 16, the latched instruction register.
REQ-010 SHALL have ports acc_clr, acc_com, acc_shr, acc_csl, acc_ld, acc_add, output, 1 each, single-cycle accumulator strobes.
REQ-011 SHALL have ports mem_re and mem_we, output, 1 each, data-memory read and write strobes; mem_addr, output, 10, driven from ir[9:0].
REQ-012 SHALL have ports halted, illegal and instr_cnt: halted and illegal output 1 bit each, illegal sticky; instr_cnt output 16 bits, counting retired instructions.

Function
REQ-013 SHALL implement states IDLE, FETCH, EXEC, MEM and HALT, with the state register reset to IDLE.
REQ-014 IDLE SHALL go to FETCH when run=1 and otherwise stay in IDLE; no strobes are asserted in IDLE.
REQ-015 FETCH SHALL do ir<=instr and go to EXEC, taking exactly one cycle.
REQ-016 EXEC SHALL decode ir[15:10] and, for one cycle only, apply the opcode action from REQ-017 to REQ-020.
REQ-017 In EXEC, opcodes 000001/000010/000011/000100 SHALL pulse acc_clr/acc_com/acc_shr/acc_csl respectively, then do pc+1 and go to FETCH; 000000 (NOP) SHALL only do pc+1 and go to FETCH.
REQ-018 In EXEC, STA (000111) SHALL pulse mem_we, do pc+1 and go to FETCH; LDA (001000) and ADD (000110) SHALL pulse mem_re, hold pc and go to MEM.
REQ-019 In EXEC, JMP (001001) SHALL set pc<=ir[7:0]; BAN (001010) SHALL set pc<=ir[7:0] if acc_neg=1 and otherwise do pc+1; both SHALL then go to FETCH.
REQ-020 In EXEC, HLT_OPC SHALL leave pc unchanged and go to HALT; any other opcode SHALL set illegal=1, act as NOP and retire.
REQ-021 MEM SHALL pulse acc_ld (LDA) or acc_add (ADD), do pc+1 and go to FETCH.
REQ-022 Latency SHALL be 2 cycles per instruction for non-memory opcodes and 3 cycles for LDA/ADD.
REQ-023 pc+1 SHALL wrap 8'hFF to 8'h00 without any flag.
REQ-024 instr_cnt SHALL increment by 1 on each retirement (the final cycle of each instruction, HLT included) and wrap at 16'hFFFF.
REQ-025 At most one strobe of acc_*/mem_* SHALL be high in any cycle.
REQ-026 mem_addr SHALL equal ir[9:0] at all times.
REQ-027 If run=0 is sampled in FETCH, the unit SHALL go to IDLE without latching ir; an instruction already in EXEC or MEM SHALL complete first.
REQ-028 HALT SHALL hold halted=1, assert no strobes, and be left only by reset.

Reset
REQ-029 When rst_n=0 at a clock edge, the unit SHALL set pc=PC_RESET, ir=0, state=IDLE, instr_cnt=0, illegal=0 and halted=0, and deassert all strobes in the following cycle.
REQ-030 Reset SHALL take priority over all other state transitions, including mid-EXEC, mid-MEM and HALT, and SHALL cancel any pending strobe.

Verification
REQ-031 SHALL cover: reset, then run=1 with ROM[0]=16'h2001 (LDA 1) -> mem_re in cycle 2, acc_ld in cycle 3, pc=1, instr_cnt=1.
REQ-032 SHALL cover: ROM[0..3]=CLA,COM,SHR,CSL -> acc_clr, acc_com, acc_shr, acc_csl each pulsed once on alternating cycles; pc=4 after 8 cycles.
REQ-033 SHALL cover: ROM[0]=16'h240E (JMP 14) -> pc=14 on the next FETCH; BAN to 2 with acc_neg=0 -> pc+1, and with acc_neg=1 -> pc=2.
REQ-034 SHALL cover: ROM[5]=16'hFC00 -> halted=1 and pc held at 5 for 20 cycles; then rst_n=0 -> pc=0, halted=0.
REQ-035 SHALL cover: opcode 6'b010101 -> illegal=1 and pc advances; a JMP at pc=8'hFF is still taken, and a NOP at pc=8'hFF wraps pc to 0.
REQ-036 SHALL cover: rst_n=0 asserted in the MEM cycle of an ADD -> no acc_add pulse, and state is IDLE on the next cycle.
